eth_llc_tx_mux: RTL

ETH_LLC_TX_MUX -- requirements
Module: eth_llc_tx_mux

---
 rtl/eth_llc_pkg.sv | 31 +++
 rtl/eth_llc_rr_arb.sv | 40 ++++
 rtl/eth_llc_tx_mux.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/eth_llc_pkg.sv
// Shared types and constants for the Ethernet LLC transmit multiplexer.
package eth_llc_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned HDR_LEN = 15;

  localparam logic [47:0] DEF_DST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] DEF_SRC_MAC  = 48'h0011_2233_4455;
  localparam logic [15:0] DEF_ETH_TYPE = 16'h88B5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Bytes carried by a beat: full beat unless last; a last beat with no keep bits still sends one byte.
  function automatic logic [3:0] beat_bytes(input logic last, input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd8;
    if (last) begin
      n = 4'd1;
      for (int unsigned i = 0; i < 8; i++) begin
        if (keep[i]) n = 4'(i + 1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_llc_rr_arb.sv
// Four-way round-robin arbiter; pointer advances past the channel whose frame completed.
module eth_llc_rr_arb
  import eth_llc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              upd_i,
  input  logic [CH_W-1:0]   upd_ch_i,
  output logic              gnt_vld_o,
  output logic [CH_W-1:0]   gnt_o
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] cand;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_o     = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = ptr_q + CH_W'(k);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_o     = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = upd_ch_i + CH_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/eth_llc_tx_mux.sv
// Muxes four AXI-Stream user channels into one byte-wide MAC stream, prefixing each frame with a 15-byte header.
module eth_llc_tx_mux
  import eth_llc_pkg::*;
#(
  parameter logic [47:0] DST_MAC  = DEF_DST_MAC,
  parameter logic [47:0] SRC_MAC  = DEF_SRC_MAC,
  parameter logic [15:0] ETH_TYPE = DEF_ETH_TYPE
) (
  input  logic                 clki,
  input  logic                 arst_ni,
  input  logic [NUM_CH-1:0]    s_axis_tvalid_user,
  output logic [NUM_CH-1:0]    s_axis_tready_user,
  input  logic [NUM_CH-1:0]    s_axis_tlast_user,
  input  logic [NUM_CH*8-1:0]  s_axis_tkeep_user,
  input  logic [NUM_CH*64-1:0] s_axis_tdata_user,
  output logic                 m_axis_tvalid_mac,
  input  logic                 m_axis_tready_mac,
  output logic                 m_axis_tlast_mac,
  output logic [7:0]           m_axis_tdata_mac,
  output logic                 keep_err_o,
  output logic [31:0]          frame_cnt_o
);

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [3:0]      hdr_idx_q, hdr_idx_d;
  logic [63:0]     buf_q, buf_d;
  logic [3:0]      rem_q, rem_d;
  logic            buf_last_q, buf_last_d;
  logic            last_ld_q, last_ld_d;
  logic            keep_err_q, keep_err_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;

  logic                gnt_vld;
  logic [CH_W-1:0]     gnt;
  logic                frame_done;
  logic                mac_acc;
  logic                buf_full;
  logic                can_load;
  logic                load;
  logic [63:0]         sel_data;
  logic [7:0]          sel_keep;
  logic                sel_last;
  logic [HDR_LEN*8-1:0] hdr_vec;
  logic [6:0]          hdr_off;

  eth_llc_rr_arb u_arb (
    .clk_i     (clki),
    .rst_ni    (arst_ni),
    .req_i     (s_axis_tvalid_user),
    .upd_i     (frame_done),
    .upd_ch_i  (grant_q),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  assign sel_data = s_axis_tdata_user[{grant_q, 6'b0} +: 64];
  assign sel_keep = s_axis_tkeep_user[{grant_q, 3'b0} +: 8];
  assign sel_last = s_axis_tlast_user[grant_q];

  assign hdr_vec  = {DST_MAC, SRC_MAC, ETH_TYPE, 6'b0, grant_q};
  assign hdr_off  = 7'((HDR_LEN - 1 - 32'(hdr_idx_q)) * 8);
  assign buf_full = (rem_q != 4'd0);
  assign mac_acc  = m_axis_tvalid_mac && m_axis_tready_mac;

  // The single beat buffer may refill in the same cycle its final byte leaves, keeping DATA gap-free.
  assign can_load = (state_q != IDLE) && !last_ld_q &&
                    (!buf_full || (state_q == DATA && mac_acc && rem_q == 4'd1));
  assign load     = can_load && s_axis_tvalid_user[grant_q];

  always_comb begin
    s_axis_tready_user          = '0;
    s_axis_tready_user[grant_q] = can_load;
  end

  always_comb begin
    m_axis_tvalid_mac = 1'b0;
    m_axis_tlast_mac  = 1'b0;
    m_axis_tdata_mac  = '0;
    case (state_q)
      HDR: begin
        m_axis_tvalid_mac = 1'b1;
        m_axis_tdata_mac  = hdr_vec[hdr_off +: 8];
      end
      DATA: begin
        m_axis_tvalid_mac = buf_full;
        m_axis_tdata_mac  = buf_q[7:0];
        m_axis_tlast_mac  = buf_full && buf_last_q && (rem_q == 4'd1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    hdr_idx_d   = hdr_idx_q;
    buf_d       = buf_q;
    rem_d       = rem_q;
    buf_last_d  = buf_last_q;
    last_ld_d   = last_ld_q;
    frame_cnt_d = frame_cnt_q;
    keep_err_d  = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d   = HDR;
          grant_d   = gnt;
          hdr_idx_d = '0;
        end
      end
      HDR: begin
        if (mac_acc) begin
          if (hdr_idx_q == 4'(HDR_LEN - 1)) state_d = DATA;
          else                              hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end
      DATA: begin
        if (mac_acc) begin
          rem_d = rem_q - 4'd1;
          buf_d = {8'h00, buf_q[63:8]};
          if (m_axis_tlast_mac) begin
            state_d     = IDLE;
            frame_done  = 1'b1;
            last_ld_d   = 1'b0;
            frame_cnt_d = frame_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      buf_d      = sel_data;
      rem_d      = beat_bytes(sel_last, sel_keep);
      buf_last_d = sel_last;
      keep_err_d = sel_last && (sel_keep == '0);
      if (sel_last) last_ld_d = 1'b1;
    end
  end

  always_ff @(posedge clki or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      hdr_idx_q   <= '0;
      buf_q       <= '0;
      rem_q       <= '0;
      buf_last_q  <= 1'b0;
      last_ld_q   <= 1'b0;
      keep_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      hdr_idx_q   <= hdr_idx_d;
      buf_q       <= buf_d;
      rem_q       <= rem_d;
      buf_last_q  <= buf_last_d;
      last_ld_q   <= last_ld_d;
      keep_err_q  <= keep_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign keep_err_o  = keep_err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
